// File: rtl/iseq_pkg.sv
// iseq_pkg: shared FSM state type and buffer pointer width helper for iseq_dispatcher_mc
package iseq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} iseq_state_t;
  localparam int MIN_PTR_W = 1;
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : MIN_PTR_W;
  endfunction
endpackage

// File: rtl/iseq_lane_buf.sv
// iseq_lane_buf: small circular FIFO staging one lane (push/pop/flush, count, head, valid)
module iseq_lane_buf
  import iseq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [PW:0]      count_o,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0] cnt_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
  assign valid_o = cnt_q != '0;
  assign count_o = cnt_q;
  // Head is forced to zero when empty so outputs read 0 out of reset.
  assign head_o = valid_o ? mem_q[rd_q] : '0;
endmodule

// File: rtl/iseq_dispatcher_mc.sv
// iseq_dispatcher_mc: multi-lane instruction-sequence dispatcher with masking, abort-flush and issue counter
// Ports: process_iseq/abort/lane_mask control; dispatcher_busy/iseq_done/iseq_aborted/instr_count status;
// instr_fifo_* and wrdata_fifo_* host FIFO side; disp_* and wrdata_* downstream valid/ack side.
module iseq_dispatcher_mc
  import iseq_pkg::*;
#(
  parameter int NUM_LANES    = 2,
  parameter int INSTR_WIDTH  = 32,
  parameter int WRDATA_WIDTH = 512,
  parameter int SLOT_DEPTH   = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             process_iseq,
  input  logic                             abort,
  input  logic [NUM_LANES-1:0]             lane_mask,
  output logic                             dispatcher_busy,
  output logic                             iseq_done,
  output logic                             iseq_aborted,
  output logic [CNT_WIDTH-1:0]             instr_count,
  output logic [NUM_LANES-1:0]             instr_fifo_rd,
  input  logic [NUM_LANES-1:0]             instr_fifo_empty,
  input  logic [NUM_LANES*INSTR_WIDTH-1:0] instr_fifo_data,
  output logic                             wrdata_fifo_rd,
  input  logic                             wrdata_fifo_empty,
  input  logic [WRDATA_WIDTH-1:0]          wrdata_fifo_data,
  output logic [NUM_LANES-1:0]             disp_en,
  input  logic [NUM_LANES-1:0]             disp_ack,
  output logic [NUM_LANES*INSTR_WIDTH-1:0] disp_instr,
  output logic                             wrdata_en,
  input  logic                             wrdata_ack,
  output logic [WRDATA_WIDTH-1:0]          wrdata
);
  localparam int PW = ptr_width(SLOT_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(SLOT_DEPTH);
  iseq_state_t state_q, state_d;
  logic [NUM_LANES-1:0] mask_q, lane_push, lane_pop, lane_valid, lane_idle;
  logic [PW:0] lane_cnt [NUM_LANES];
  logic [PW:0] wr_cnt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH+3:0] sum;
  logic aborted_q, run, flush_st, flush_buf, wr_push, wr_pop, wr_valid;
  assign run = state_q == ST_RUN;
  assign flush_st = state_q == ST_FLUSH;
  assign flush_buf = run & abort;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_push[i] = run & mask_q[i] & ~instr_fifo_empty[i] & (lane_cnt[i] < DEPTH_C);
    assign instr_fifo_rd[i] = lane_push[i] | (flush_st & mask_q[i] & ~instr_fifo_empty[i]);
    // Lane buffers only hold data while RUN (drained before DONE, flushed on abort).
    assign disp_en[i] = lane_valid[i];
    assign lane_pop[i] = lane_valid[i] & disp_ack[i];
    // Lane finishes this cycle if its FIFO is dry and the buffer empties after this edge.
    assign lane_idle[i] = ~mask_q[i] | (instr_fifo_empty[i] &
                          ((lane_cnt[i] == '0) | ((lane_cnt[i] == (PW+1)'(1)) & lane_pop[i])));
    iseq_lane_buf #(.WIDTH(INSTR_WIDTH), .DEPTH(SLOT_DEPTH)) u_buf (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_buf), .push_i(lane_push[i]), .pop_i(lane_pop[i]),
      .data_i(instr_fifo_data[i*INSTR_WIDTH +: INSTR_WIDTH]), .count_o(lane_cnt[i]),
      .head_o(disp_instr[i*INSTR_WIDTH +: INSTR_WIDTH]), .valid_o(lane_valid[i])
    );
  end
  assign wr_push = run & ~wrdata_fifo_empty & (wr_cnt < DEPTH_C);
  assign wrdata_fifo_rd = wr_push | (flush_st & ~wrdata_fifo_empty);
  // Staged wrdata survives DONE/IDLE, so it is only offered while running.
  assign wrdata_en = run & wr_valid;
  assign wr_pop = wrdata_en & wrdata_ack;
  iseq_lane_buf #(.WIDTH(WRDATA_WIDTH), .DEPTH(SLOT_DEPTH)) u_wr_buf (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_buf), .push_i(wr_push), .pop_i(wr_pop),
    .data_i(wrdata_fifo_data), .count_o(wr_cnt), .head_o(wrdata), .valid_o(wr_valid)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (process_iseq) state_d = ST_RUN;
      ST_RUN: if (abort) state_d = ST_FLUSH; else if (&lane_idle) state_d = ST_DONE;
      ST_FLUSH: if (!(|(mask_q & ~instr_fifo_empty)) && wrdata_fifo_empty) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  assign sum = {4'b0, cnt_q} + (CNT_WIDTH+4)'($countones(lane_pop));
  assign cnt_d = (sum > {4'b0, {CNT_WIDTH{1'b1}}}) ? '1 : sum[CNT_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q <= '0;
      cnt_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && process_iseq) begin
        mask_q <= lane_mask;
        cnt_q <= '0;
        aborted_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
      end
      if (flush_st && state_d == ST_DONE) aborted_q <= 1'b1;
    end
  end
  assign dispatcher_busy = run | flush_st;
  assign iseq_done = state_q == ST_DONE;
  assign iseq_aborted = aborted_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_iseq_dispatcher_mc.sv
// tb_iseq_dispatcher_mc: randomized self-checking bench with a queue-based reference model
module tb_iseq_dispatcher_mc;
  localparam int NL = 2, IW = 16, WW = 32, SD = 2, CW = 4;
  logic clk = 0, rst_n = 0, process_iseq = 0, abort = 0;
  logic [NL-1:0] lane_mask = '0, instr_fifo_empty = '1, disp_ack = '0;
  logic [NL-1:0] instr_fifo_rd, disp_en;
  logic [NL*IW-1:0] instr_fifo_data = '0, disp_instr;
  logic wrdata_fifo_empty = 1, wrdata_ack = 0, wrdata_fifo_rd, wrdata_en;
  logic [WW-1:0] wrdata_fifo_data = '0, wrdata;
  logic dispatcher_busy, iseq_done, iseq_aborted;
  logic [CW-1:0] instr_count;
  iseq_dispatcher_mc #(.NUM_LANES(NL), .INSTR_WIDTH(IW), .WRDATA_WIDTH(WW), .SLOT_DEPTH(SD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .process_iseq(process_iseq), .abort(abort), .lane_mask(lane_mask),
    .dispatcher_busy(dispatcher_busy), .iseq_done(iseq_done), .iseq_aborted(iseq_aborted),
    .instr_count(instr_count), .instr_fifo_rd(instr_fifo_rd), .instr_fifo_empty(instr_fifo_empty),
    .instr_fifo_data(instr_fifo_data), .wrdata_fifo_rd(wrdata_fifo_rd), .wrdata_fifo_empty(wrdata_fifo_empty),
    .wrdata_fifo_data(wrdata_fifo_data), .disp_en(disp_en), .disp_ack(disp_ack), .disp_instr(disp_instr),
    .wrdata_en(wrdata_en), .wrdata_ack(wrdata_ack), .wrdata(wrdata)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  // Model: host FIFO contents, words popped but not yet acked (per lane), phase 0 idle/1 run/2 flush/3 done.
  logic [IW-1:0] src [NL][$];
  logic [IW-1:0] exp_q [NL][$];
  logic [WW-1:0] wsrc [$];
  logic [WW-1:0] wexp [$];
  int phase = 0, acked = 0;
  logic ab = 0;
  logic [NL-1:0] mask_m = '0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_zero();
    check("rst_busy", dispatcher_busy, 0);
    check("rst_done", iseq_done, 0);
    check("rst_aborted", iseq_aborted, 0);
    check("rst_count", instr_count, 0);
    check("rst_rd", instr_fifo_rd, 0);
    check("rst_en", disp_en, 0);
    check("rst_instr", disp_instr, 0);
    check("rst_wrd", wrdata_fifo_rd, 0);
    check("rst_wen", wrdata_en, 0);
    check("rst_wrdata", wrdata, 0);
  endtask
  task automatic step(input logic [NL-1:0] ack, input logic wack, input logic ab_in, input logic start,
                      input logic [NL-1:0] msk);
    logic [NL-1:0] erd, een;
    logic ewrd, ewen, idle_all;
    logic [IW-1:0] w;
    logic [WW-1:0] ww;
    for (int i = 0; i < NL; i++) begin
      instr_fifo_empty[i] = src[i].size() == 0;
      instr_fifo_data[i*IW +: IW] = (src[i].size() != 0) ? src[i][0] : '0;
    end
    wrdata_fifo_empty = wsrc.size() == 0;
    wrdata_fifo_data = (wsrc.size() != 0) ? wsrc[0] : '0;
    disp_ack = ack;
    wrdata_ack = wack;
    abort = ab_in;
    process_iseq = start;
    lane_mask = msk;
    #1;
    for (int i = 0; i < NL; i++) begin
      erd[i] = mask_m[i] && src[i].size() != 0 && (phase == 2 || (phase == 1 && exp_q[i].size() < SD));
      een[i] = phase == 1 && exp_q[i].size() != 0;
    end
    ewrd = wsrc.size() != 0 && (phase == 2 || (phase == 1 && wexp.size() < SD));
    ewen = phase == 1 && wexp.size() != 0;
    check("busy", dispatcher_busy, phase == 1 || phase == 2);
    check("done", iseq_done, phase == 3);
    check("aborted", iseq_aborted, ab);
    check("count", instr_count, (acked > 15) ? 15 : acked);
    check("instr_rd", instr_fifo_rd, erd);
    check("disp_en", disp_en, een);
    check("wr_rd", wrdata_fifo_rd, ewrd);
    check("wr_en", wrdata_en, ewen);
    for (int i = 0; i < NL; i++) begin
      if (een[i] && ack[i]) begin
        check("disp_instr", disp_instr[i*IW +: IW], exp_q[i][0]);
        void'(exp_q[i].pop_front());
        acked++;
      end
      if (erd[i]) begin
        w = src[i].pop_front();
        if (phase == 1 && !ab_in) exp_q[i].push_back(w);
      end
    end
    if (ewen && wack) begin
      check("wrdata", wrdata, wexp[0]);
      void'(wexp.pop_front());
    end
    if (ewrd) begin
      ww = wsrc.pop_front();
      if (phase == 1 && !ab_in) wexp.push_back(ww);
    end
    case (phase)
      0: if (start) begin phase = 1; mask_m = msk; acked = 0; ab = 0; end
      1: begin
        idle_all = 1;
        for (int i = 0; i < NL; i++) if (mask_m[i] && (src[i].size() != 0 || exp_q[i].size() != 0)) idle_all = 0;
        if (ab_in) begin
          for (int i = 0; i < NL; i++) exp_q[i].delete();
          wexp.delete();
          phase = 2;
        end else if (idle_all) phase = 3;
      end
      2: if (erd == '0 && !ewrd) begin phase = 3; ab = 1; end
      default: phase = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic load(input int nw);
    for (int i = 0; i < NL; i++) for (int k = 0; k < nw; k++) src[i].push_back(IW'($urandom));
    repeat ($urandom_range(0, 3)) wsrc.push_back($urandom);
  endtask
  task automatic seq(input logic [NL-1:0] msk, input int nw, input int pct, input int stall, input int abort_at);
    logic [NL-1:0] a;
    int cyc;
    load(nw);
    step(NL'($urandom), 1'($urandom), 0, 1, msk);
    cyc = 0;
    while (phase != 0 && cyc < 300) begin
      for (int i = 0; i < NL; i++) a[i] = cyc >= stall && $urandom_range(1, 100) <= pct;
      step(a, cyc >= stall && $urandom_range(0, 1) == 1, abort_at >= 0 && phase == 1 && acked >= abort_at,
           1'($urandom), NL'($urandom));
      cyc++;
    end
    if (phase != 0) check("timeout", phase, 0);
    step(NL'($urandom), 1'($urandom), 1'($urandom), 0, '0);
  endtask
  task automatic mid_reset();
    #2 rst_n = 0;
    #1 check_zero();
    for (int i = 0; i < NL; i++) begin src[i].delete(); exp_q[i].delete(); end
    wsrc.delete();
    wexp.delete();
    phase = 0; acked = 0; ab = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_zero();
    rst_n = 1;
    @(negedge clk);
    seq(2'b11, 3, 100, 0, -1);
    seq(2'b01, 4, 100, 0, -1);
    seq(2'b11, 3, 100, 5, -1);
    seq(2'b01, 8, 100, 0, 2);
    load(4);
    step('0, 0, 0, 1, 2'b11);
    repeat (3) step('1, 1, 0, 0, '0);
    mid_reset();
    seq(2'b11, 3, 100, 0, -1);
    seq(2'b11, 10, 100, 0, -1);
    repeat (25) seq(NL'($urandom), $urandom_range(0, 6), $urandom_range(30, 100), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
